// File: rtl/counter_seg7_display.sv
// Binary-to-decimal converter and multiplexed common-anode seven-segment driver for the 8-bit counter value.
// Build option SEG7_HEX_MODE_EN: two-digit hex display with a direct register in place of the conversion FSM.
//
// state | meaning
// IDLE  | wait for a new value (or the forced start after reset), then capture it
// SHIFT | eight add-3 / shift-left double-dabble steps
// DONE  | publish scratch to the display register, pulse bcd_valid
module counter_seg7_display #(
  parameter int REFRESH_DIV   = 100_000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic [7:0] value,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [7:0] AN,
  output logic       bcd_valid
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [11:0]   disp_bcd;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    an_d;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0:    seg_of = 7'b1000000;
      4'h1:    seg_of = 7'b1111001;
      4'h2:    seg_of = 7'b0100100;
      4'h3:    seg_of = 7'b0110000;
      4'h4:    seg_of = 7'b0011001;
      4'h5:    seg_of = 7'b0010010;
      4'h6:    seg_of = 7'b0000010;
      4'h7:    seg_of = 7'b1111000;
      4'h8:    seg_of = 7'b0000000;
      4'h9:    seg_of = 7'b0010000;
`ifdef SEG7_HEX_MODE_EN
      4'hA:    seg_of = 7'b0001000;
      4'hB:    seg_of = 7'b0000011;
      4'hC:    seg_of = 7'b1000110;
      4'hD:    seg_of = 7'b0100001;
      4'hE:    seg_of = 7'b0000110;
      4'hF:    seg_of = 7'b0001110;
`endif
      default: seg_of = 7'b1111111;
    endcase
  endfunction

`ifdef SEG7_HEX_MODE_EN
  localparam logic [1:0] IDX_MAX = 2'd1;

  logic [7:0] last_val;
  logic       force_start;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      last_val    <= '0;
      force_start <= 1'b1;
      disp_bcd    <= '0;
      bcd_valid   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (force_start || (value != last_val)) begin
        last_val    <= value;
        force_start <= 1'b0;
        disp_bcd    <= {4'h0, value};
        bcd_valid   <= 1'b1;
      end
    end
  end
`else
  localparam logic [1:0] IDX_MAX = 2'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_d;
  logic [7:0]  cap_val, cap_val_d;
  logic [7:0]  sh, sh_d;
  logic [11:0] scratch, scratch_d, adj;
  logic [2:0]  step_cnt, step_cnt_d;
  logic        force_start, force_start_d;
  logic [11:0] disp_bcd_d;
  logic        bcd_valid_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state       <= IDLE;
      cap_val     <= '0;
      sh          <= '0;
      scratch     <= '0;
      step_cnt    <= '0;
      force_start <= 1'b1;
      disp_bcd    <= '0;
      bcd_valid   <= 1'b0;
    end else begin
      state       <= state_d;
      cap_val     <= cap_val_d;
      sh          <= sh_d;
      scratch     <= scratch_d;
      step_cnt    <= step_cnt_d;
      force_start <= force_start_d;
      disp_bcd    <= disp_bcd_d;
      bcd_valid   <= bcd_valid_d;
    end
  end

  // cap_val keeps the captured value for the IDLE compare; sh is the copy consumed by the shifts
  always_comb begin
    state_d       = state;
    cap_val_d     = cap_val;
    sh_d          = sh;
    scratch_d     = scratch;
    step_cnt_d    = step_cnt;
    force_start_d = force_start;
    disp_bcd_d    = disp_bcd;
    bcd_valid_d   = 1'b0;
    adj           = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    case (state)
      IDLE: begin
        if (force_start || (value != cap_val)) begin
          cap_val_d     = value;
          sh_d          = value;
          scratch_d     = '0;
          step_cnt_d    = 3'd7;
          force_start_d = 1'b0;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, sh_d} = {adj, sh} << 1;
        step_cnt_d        = step_cnt - 3'd1;
        if (step_cnt == 3'd0) state_d = DONE;
      end
      DONE: begin
        disp_bcd_d  = scratch;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_MAX) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_comb begin
    nib   = disp_bcd[3:0];
    blank = 1'b0;
    case (digit_idx)
      2'd1: begin
        nib = disp_bcd[7:4];
`ifdef SEG7_HEX_MODE_EN
        blank = BLANK_LEADING && (disp_bcd[7:4] == 4'h0);
`else
        blank = BLANK_LEADING && (disp_bcd[11:8] == 4'h0) && (disp_bcd[7:4] == 4'h0);
`endif
      end
      2'd2: begin
        nib   = disp_bcd[11:8];
        blank = BLANK_LEADING && (disp_bcd[11:8] == 4'h0);
      end
      default: ;
    endcase
    an_d = 8'hFF;
    if (!blank) an_d[digit_idx] = 1'b0;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      SEG <= 7'h7F;
      AN  <= 8'hFF;
    end else begin
      SEG <= seg_of(nib);
      AN  <= an_d;
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_counter_seg7_display.sv
// Randomised self-checking bench for counter_seg7_display against an arithmetic display model.
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_counter_seg7_display;
  localparam int RDIV = 4;
`ifdef SEG7_HEX_MODE_EN
  localparam int NDIG = 2;
  localparam int FIRST_PULSE = 1;
`else
  localparam int NDIG = 3;
  localparam int FIRST_PULSE = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic [6:0] SEG, SEG_nb;
  logic       DP, DP_nb;
  logic [7:0] AN, AN_nb;
  logic       bcd_valid, bcd_valid_nb;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int         k;
  bit         m_force, m_busy;
  logic [7:0] m_cap;
  int         m_conv, m_done, m_disp;
  logic [7:0] exp_an, exp_an_nb;
  logic [6:0] exp_seg;
  logic       exp_valid;
  logic [6:0] seg_tab [16];

  counter_seg7_display #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b1)) dut (
    .CLK100MHZ(clk), .rst(rst), .value(value),
    .SEG(SEG), .DP(DP), .AN(AN), .bcd_valid(bcd_valid));

  counter_seg7_display #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b0)) dut_nb (
    .CLK100MHZ(clk), .rst(rst), .value(value),
    .SEG(SEG_nb), .DP(DP_nb), .AN(AN_nb), .bcd_valid(bcd_valid_nb));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge, update the model from the pre-edge inputs, sample 1 ns later.
  task automatic tick();
    int old, s, d0, d1, d2, dsel;
    bit bl;
    @(posedge clk);
    if (rst) begin
      k = 0; m_force = 1; m_busy = 0; m_disp = 0; m_cap = 8'd0;
      exp_an = 8'hFF; exp_an_nb = 8'hFF; exp_seg = 7'h7F; exp_valid = 1'b0;
    end else begin
      k++;
      old = m_disp;
      s = ((k - 1) / RDIV) % NDIG;
`ifdef SEG7_HEX_MODE_EN
      d0 = old % 16; d1 = old / 16; d2 = 0;
      bl = (s == 1) && (d1 == 0);
`else
      d0 = old % 10; d1 = (old / 10) % 10; d2 = old / 100;
      bl = ((s == 2) && (d2 == 0)) || ((s == 1) && (d2 == 0) && (d1 == 0));
`endif
      dsel = (s == 0) ? d0 : (s == 1) ? d1 : d2;
      exp_seg   = seg_tab[dsel];
      exp_an_nb = ~(8'd1 << s);
      exp_an    = bl ? 8'hFF : exp_an_nb;
      exp_valid = 1'b0;
`ifdef SEG7_HEX_MODE_EN
      if (m_force || value != m_cap) begin
        m_cap = value; m_disp = value; m_force = 0; exp_valid = 1'b1;
      end
`else
      if (m_busy) begin
        if (k == m_done) begin m_disp = m_conv; m_busy = 0; exp_valid = 1'b1; end
      end else if (m_force || value != m_cap) begin
        m_cap = value; m_conv = value; m_done = k + 9; m_busy = 1; m_force = 0;
      end
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    int pulses = 0, pulse_k = -1;
    rst = 1'b1; value = 8'd0;
    repeat (3) tick();
    n_checks += 5;
    if (SEG !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %b expected %b", SEG, 7'h7F); end
    if (AN !== 8'hFF) begin n_fail++; $display("FAIL reset_an got %h expected FF", AN); end
    if (DP !== 1'b1 || DP_nb !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b/%b expected 1", DP, DP_nb); end
    if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", bcd_valid); end
    if (AN_nb !== 8'hFF) begin n_fail++; $display("FAIL reset_an_nb got %h expected FF", AN_nb); end
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin pulses++; pulse_k = k; end
      n_checks += 4;
      if (AN !== exp_an) begin n_fail++; $display("FAIL zero_an k=%0d got %h expected %h", k, AN, exp_an); end
      if (AN_nb !== exp_an_nb) begin n_fail++; $display("FAIL zero_an_nb k=%0d got %h expected %h", k, AN_nb, exp_an_nb); end
      if (SEG !== exp_seg) begin n_fail++; $display("FAIL zero_seg k=%0d got %b expected %b", k, SEG, exp_seg); end
      if (bcd_valid !== exp_valid) begin n_fail++; $display("FAIL zero_valid k=%0d got %b expected %b", k, bcd_valid, exp_valid); end
    end
    n_checks += 2;
    if (pulses != 1) begin n_fail++; $display("FAIL zero_pulse_count got %0d expected 1", pulses); end
    if (pulse_k != FIRST_PULSE) begin n_fail++; $display("FAIL zero_pulse_edge got %0d expected %0d", pulse_k, FIRST_PULSE); end
  endtask

  task automatic test_hold(input logic [7:0] v, input int cycles, input string tag);
    value = v;
    for (int i = 0; i < cycles; i++) begin
      tick();
      n_checks += 5;
      if (AN !== exp_an) begin n_fail++; $display("FAIL %s_an v=%0d k=%0d got %h expected %h", tag, v, k, AN, exp_an); end
      if (AN_nb !== exp_an_nb) begin n_fail++; $display("FAIL %s_an_nb v=%0d k=%0d got %h expected %h", tag, v, k, AN_nb, exp_an_nb); end
      if (SEG !== exp_seg) begin n_fail++; $display("FAIL %s_seg v=%0d k=%0d got %b expected %b", tag, v, k, SEG, exp_seg); end
      if (SEG_nb !== exp_seg) begin n_fail++; $display("FAIL %s_seg_nb v=%0d k=%0d got %b expected %b", tag, v, k, SEG_nb, exp_seg); end
      if (bcd_valid !== exp_valid) begin n_fail++; $display("FAIL %s_valid v=%0d k=%0d got %b expected %b", tag, v, k, bcd_valid, exp_valid); end
    end
  endtask

`ifndef SEG7_HEX_MODE_EN
  task automatic test_value_255();
    int seen_fb = 0;
    test_hold(8'd255, 40, "v255");
    for (int i = 0; i < 12; i++) begin
      tick();
      if (AN === 8'hFB) begin
        seen_fb++;
        n_checks++;
        if (SEG !== 7'b0100100) begin n_fail++; $display("FAIL v255_hundreds got %b expected 0100100", SEG); end
      end
    end
    n_checks++;
    if (seen_fb != 4) begin n_fail++; $display("FAIL v255_fb_slot_len got %0d expected 4", seen_fb); end
  endtask

  task automatic test_change_mid();
    int kc = -1, np = 0;
    int pk [2];
    value = 8'd100;
    for (int i = 0; i < 20 && kc < 0; i++) begin
      tick();
      if (m_busy && m_cap == 8'd100) kc = k;
    end
    n_checks++;
    if (kc < 0) begin n_fail++; $display("FAIL mid_capture got none expected capture of 100"); end
    repeat (3) tick();
    value = 8'd101;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin
        if (np < 2) pk[np] = k;
        np++;
      end
      n_checks += 3;
      if (AN !== exp_an) begin n_fail++; $display("FAIL mid_an k=%0d got %h expected %h", k, AN, exp_an); end
      if (SEG !== exp_seg) begin n_fail++; $display("FAIL mid_seg k=%0d got %b expected %b", k, SEG, exp_seg); end
      if (bcd_valid !== exp_valid) begin n_fail++; $display("FAIL mid_valid k=%0d got %b expected %b", k, bcd_valid, exp_valid); end
    end
    n_checks++;
    if (np != 2) begin n_fail++; $display("FAIL mid_pulse_count got %0d expected 2", np); end
    else begin
      n_checks += 2;
      if (pk[0] != kc + 9) begin n_fail++; $display("FAIL mid_first_pulse got %0d expected %0d", pk[0], kc + 9); end
      if (pk[1] - pk[0] != 10) begin n_fail++; $display("FAIL mid_pulse_gap got %0d expected 10", pk[1] - pk[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int np = 0, pulse_k = -1, seen = 0;
    bit got_cap = 0;
    value = 8'd200;
    for (int i = 0; i < 20 && !got_cap; i++) begin
      tick();
      got_cap = m_busy && (m_cap == 8'd200);
    end
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) begin
      tick();
      n_checks += 3;
      if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b expected 0", bcd_valid); end
      if (SEG !== 7'h7F) begin n_fail++; $display("FAIL rmid_seg got %b expected 1111111", SEG); end
      if (AN !== 8'hFF) begin n_fail++; $display("FAIL rmid_an got %h expected FF", AN); end
    end
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin np++; pulse_k = k; end
    end
    n_checks += 2;
    if (np != 1) begin n_fail++; $display("FAIL rmid_pulse_count got %0d expected 1", np); end
    if (pulse_k != 10) begin n_fail++; $display("FAIL rmid_pulse_edge got %0d expected 10", pulse_k); end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      case (AN)
        8'hFE: begin seen++; if (SEG !== 7'b1000000) begin n_fail++; $display("FAIL rmid_units got %b expected 1000000", SEG); end end
        8'hFD: begin seen++; if (SEG !== 7'b1000000) begin n_fail++; $display("FAIL rmid_tens got %b expected 1000000", SEG); end end
        8'hFB: begin seen++; if (SEG !== 7'b0100100) begin n_fail++; $display("FAIL rmid_hundreds got %b expected 0100100", SEG); end end
        default: begin n_fail++; $display("FAIL rmid_an got %h expected FE/FD/FB", AN); end
      endcase
    end
    n_checks++;
    if (seen != 12) begin n_fail++; $display("FAIL rmid_slots got %0d expected 12", seen); end
  endtask
`else
  task automatic test_hex();
    int lat = -1;
    value = 8'hA5;
    for (int i = 1; i <= 5 && lat < 0; i++) begin
      tick();
      if (bcd_valid === 1'b1) lat = i;
    end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL hex_latency got %0d expected 1", lat); end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      case (AN)
        8'hFE: if (SEG !== 7'b0010010) begin n_fail++; $display("FAIL hex_low got %b expected 0010010", SEG); end
        8'hFD: if (SEG !== 7'b0001000) begin n_fail++; $display("FAIL hex_high got %b expected 0001000", SEG); end
        default: begin n_fail++; $display("FAIL hex_an got %h expected FE/FD", AN); end
      endcase
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 20; n++) begin
      v = 8'($urandom_range(0, 255));
      if (n % 5 == 0) v = 8'($urandom_range(0, 12));
      test_hold(v, int'($urandom_range(3, 40)), "rand");
    end
    test_hold(8'd42, 40, "rand_settle");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seg_tab[i] = 7'b1111111;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
`ifdef SEG7_HEX_MODE_EN
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011; seg_tab[12] = 7'b1000110;
    seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
`endif
    test_reset();
`ifndef SEG7_HEX_MODE_EN
    test_value_255();
`else
    test_hex();
`endif
    test_hold(8'd7, 36, "v7");
    test_hold(8'd0, 30, "v0");
    test_hold(8'd60, 30, "v60");
`ifndef SEG7_HEX_MODE_EN
    test_change_mid();
    test_reset_mid();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_seg7_display.md
Name: counter_seg7_display

Overview:
- Downstream consumer of the 8-bit up/down counter value, which normally drives LED[7:0].
- Converts the unsigned 8-bit value to three decimal digits (0-255) with a sequential double-dabble FSM.
- Time-multiplexes the digits onto the board's 8-digit common-anode seven-segment display.
- Runs entirely on CLK100MHZ; the counter's slow tick never clocks this block.

Parameters:
- REFRESH_DIV, 100_000: CLK100MHZ cycles each digit stays lit (1 ms/digit). Legal range 2..2^20.
- BLANK_LEADING, 1: 1 = suppress leading zeros on hundreds/tens digits; 0 = always show three digits.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  8  unsigned counter value to display; must be synchronous to CLK100MHZ.
- SEG  output  7  segment cathodes, active low; SEG[6:0] = {CG,CF,CE,CD,CC,CB,CA}.
- DP  output  1  decimal point, active low; held 1 (off).
- AN  output  8  digit anodes, active low; AN[0] = rightmost digit.
- bcd_valid  output  1  one-cycle pulse when a new conversion result is loaded into the display register.

Behaviour:
- Reset values (rst sampled high): SEG=7'h7F, DP=1, AN=8'hFF, bcd_valid=0. Refresh counter=0, digit index=0, display BCD register=12'h000, FSM=IDLE with force-start flag set.
- rst high mid-conversion aborts the conversion; no bcd_valid pulse is produced.
- Conversion FSM states:
  - IDLE: on each edge, if the force flag is set or value != captured value, capture value, clear the 12-bit BCD scratch, go to SHIFT. The force flag clears on this capture.
  - SHIFT: 8 cycles. Each cycle: add 3 to every scratch nibble >= 5, then shift {scratch, capture} left by 1.
  - DONE: one cycle. Load the scratch into the display register, bcd_valid=1, return to IDLE.
- Timing: capture edge E, SHIFT edges E+1..E+8, DONE edge E+9. bcd_valid is high for exactly the cycle after edge E+9.
- Changes to value during SHIFT/DONE are ignored. The IDLE compare picks them up, so the final displayed value always equals the last stable value.
- The display register updates only in DONE. Digits never show a partially converted result.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances 0 (units) -> 1 (tens) -> 2 (hundreds) -> 0.
  - AN = ~(one-hot of digit index); AN[7:3] always 1.
  - SEG/AN are registered and change on the edge after the index changes; no overlap between digits.
- Blanking (BLANK_LEADING=1):
  - Hundreds digit's AN bit forced 1 when hundreds==0.
  - Tens digit's AN bit forced 1 when hundreds==0 and tens==0.
  - Units digit is never blanked.
  - Scan timing is unchanged; the blanked slot is simply dark.
- Segment patterns, active low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble = 1111111.

Optional Feature:
- SEG7_HEX_MODE_EN defined:
  - Conversion FSM is replaced by a direct register. The display register loads {4'h0, value} one cycle after a change is detected, and bcd_valid pulses on that load; there is no 9-cycle conversion.
  - Digit index cycles 0 -> 1 -> 0 over AN[1:0]; AN[7:2] always 1.
  - Adds hex patterns A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Blanking applies only to the upper nibble when it is 0.
- SEG7_HEX_MODE_EN undefined: decimal behaviour as above.

Test Plan:
All scenarios use REFRESH_DIV=4 unless stated.
- Reset, value=0, rst released:
  - bcd_valid pulses once, in the cycle after the 10th edge after release.
  - Scan shows AN=FE, SEG=1000000; AN=FF for the tens and hundreds slots.
- value=255 held:
  - After bcd_valid, AN sequence FE/FD/FB, 4 cycles each.
  - SEG sequence 0010010 / 0010010 / 0100100, repeating.
- value=7, BLANK_LEADING=1: AN sequence FE/FF/FF, SEG=1111000 during the FE slot.
- Same as above with BLANK_LEADING=0: AN FE/FD/FB, SEG 1111000/1000000/1000000.
- value changed 100->101 three cycles after the capture of 100:
  - Two bcd_valid pulses, 10 cycles apart.
  - Display shows 100, then 101; never any other value.
- rst asserted during SHIFT for value=200:
  - No bcd_valid pulse; outputs return to reset values.
  - After release, a fresh conversion yields 2,0,0.
- SEG7_HEX_MODE_EN, value=8'hA5:
  - AN FE with SEG 0010010, then AN FD with SEG 0001000.
  - bcd_valid is 1 cycle after the change.
